// File: rtl/magn_calc_pipe.sv
// Three-stage |x|^2 pipeline for FFT bins with shared valid/ready stall,
// shift/saturate scaling, per-frame bin numbering and peak tracking.
module magn_calc_pipe #(
  parameter int IN_W     = 32,
  parameter int OUT_W    = 64,
  parameter int SHIFT    = 0,
  parameter int N_POINTS = 1024
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic signed [IN_W-1:0]      in_real,
  input  logic signed [IN_W-1:0]      in_img,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [OUT_W-1:0]            out_magn,
  output logic [$clog2(N_POINTS)-1:0] out_bin,
  output logic                        out_last,
  output logic                        peak_valid,
  output logic [OUT_W-1:0]            peak_magn,
  output logic [$clog2(N_POINTS)-1:0] peak_bin
);
  localparam int SUM_W = 2 * IN_W;
  localparam int BIN_W = $clog2(N_POINTS);
  localparam logic [BIN_W-1:0] LAST_BIN = BIN_W'(N_POINTS - 1);

  logic                   advance;
  logic                   out_hs;
  logic                   s1_valid_reg;
  logic signed [IN_W-1:0] s1_comp_reg [2];
  logic                   s2_valid_reg;
  logic [SUM_W-1:0]       s2_sq_reg [2];
  logic [SUM_W-1:0]       sq_next [2];
  logic [SUM_W-1:0]       sum;
  logic [SUM_W-1:0]       scaled;
  logic [OUT_W-1:0]       sat_magn;
  logic                   out_valid_reg;
  logic [OUT_W-1:0]       out_magn_reg;
  logic [BIN_W-1:0]       out_bin_reg;
  logic [BIN_W-1:0]       bin_cnt_reg;
  logic [BIN_W-1:0]       bin_cnt_next;
  logic [OUT_W-1:0]       max_magn_reg;
  logic [BIN_W-1:0]       max_bin_reg;
  logic                   take_current;
  logic [OUT_W-1:0]       frame_max;
  logic [BIN_W-1:0]       frame_bin;
  logic                   peak_valid_reg;
  logic [OUT_W-1:0]       peak_magn_reg;
  logic [BIN_W-1:0]       peak_bin_reg;

  assign advance  = !out_valid_reg || out_ready;
  assign in_ready = advance;
  assign out_hs   = out_valid_reg && out_ready;

  // Index 0 is the real part, index 1 the imaginary part.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_sq
      logic signed [SUM_W-1:0] comp_ext;
      assign comp_ext    = SUM_W'(s1_comp_reg[gi]);
      assign sq_next[gi] = $unsigned(comp_ext * comp_ext);
    end
  endgenerate

  // Two squares of at most 2^(2*IN_W-2) each cannot overflow SUM_W bits.
  assign sum    = s2_sq_reg[0] + s2_sq_reg[1];
  assign scaled = sum >> SHIFT;

  generate
    if (SUM_W > OUT_W) begin : g_sat
      assign sat_magn = (|scaled[SUM_W-1:OUT_W]) ? '1 : scaled[OUT_W-1:0];
    end else begin : g_ext
      assign sat_magn = OUT_W'(scaled);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_reg   <= 1'b0;
      s1_comp_reg[0] <= '0;
      s1_comp_reg[1] <= '0;
      s2_valid_reg   <= 1'b0;
      s2_sq_reg[0]   <= '0;
      s2_sq_reg[1]   <= '0;
      out_valid_reg  <= 1'b0;
      out_magn_reg   <= '0;
      out_bin_reg    <= '0;
    end else if (advance) begin
      s1_valid_reg   <= in_valid;
      s1_comp_reg[0] <= in_real;
      s1_comp_reg[1] <= in_img;
      s2_valid_reg   <= s1_valid_reg;
      s2_sq_reg[0]   <= sq_next[0];
      s2_sq_reg[1]   <= sq_next[1];
      out_valid_reg  <= s2_valid_reg;
      out_magn_reg   <= sat_magn;
      out_bin_reg    <= bin_cnt_next;
    end
  end

  // The bin tag must already include a handshake that retires on this same edge.
  assign bin_cnt_next = out_hs ? bin_cnt_reg + 1'b1 : bin_cnt_reg;

  always_ff @(posedge clk) begin
    if (reset) bin_cnt_reg <= '0;
    else       bin_cnt_reg <= bin_cnt_next;
  end

  assign take_current = (out_bin_reg == '0) || (out_magn_reg > max_magn_reg);
  assign frame_max    = take_current ? out_magn_reg : max_magn_reg;
  assign frame_bin    = take_current ? out_bin_reg  : max_bin_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      max_magn_reg   <= '0;
      max_bin_reg    <= '0;
      peak_valid_reg <= 1'b0;
      peak_magn_reg  <= '0;
      peak_bin_reg   <= '0;
    end else begin
      peak_valid_reg <= 1'b0;
      if (out_hs) begin
        max_magn_reg <= frame_max;
        max_bin_reg  <= frame_bin;
        if (out_last) begin
          peak_valid_reg <= 1'b1;
          peak_magn_reg  <= frame_max;
          peak_bin_reg   <= frame_bin;
        end
      end
    end
  end

  assign out_valid  = out_valid_reg;
  assign out_magn   = out_magn_reg;
  assign out_bin    = out_bin_reg;
  assign out_last   = out_valid_reg && (out_bin_reg == LAST_BIN);
  assign peak_valid = peak_valid_reg;
  assign peak_magn  = peak_magn_reg;
  assign peak_bin   = peak_bin_reg;
endmodule

// File: tb/tb_magn_calc_pipe.sv
// Bench for magn_calc_pipe: queue-based reference model checked every cycle,
// plus directed literal checks on a default and a scaled/saturating instance.
module tb_magn_calc_pipe;
  localparam int N  = 1024;
  localparam int BW = 10;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic               in_valid, in_ready, out_valid, out_ready, out_last, peak_valid;
  logic signed [31:0] in_real, in_img;
  logic [63:0]        out_magn, peak_magn;
  logic [BW-1:0]      out_bin, peak_bin;

  logic               b_in_valid, b_in_ready, b_out_valid, b_out_last, b_peak_valid;
  logic               b_out_ready;
  logic signed [31:0] b_real, b_img;
  logic [31:0]        b_out_magn, b_peak_magn;
  logic [1:0]         b_out_bin, b_peak_bin;

  magn_calc_pipe #(.IN_W(32), .OUT_W(64), .SHIFT(0), .N_POINTS(N)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_real(in_real), .in_img(in_img), .out_valid(out_valid), .out_ready(out_ready),
    .out_magn(out_magn), .out_bin(out_bin), .out_last(out_last),
    .peak_valid(peak_valid), .peak_magn(peak_magn), .peak_bin(peak_bin)
  );

  magn_calc_pipe #(.IN_W(32), .OUT_W(32), .SHIFT(16), .N_POINTS(4)) dut_b (
    .clk(clk), .reset(reset), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_real(b_real), .in_img(b_img), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_magn(b_out_magn), .out_bin(b_out_bin), .out_last(b_out_last),
    .peak_valid(b_peak_valid), .peak_magn(b_peak_magn), .peak_bin(b_peak_bin)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] model_magn(input logic signed [31:0] re, input logic signed [31:0] im);
    longint r, i;
    logic [63:0] s;
    r = re;
    i = im;
    s = r * r;
    s = s + i * i;
    return s;
  endfunction

  // ---------------- reference model / compare process ----------------
  logic [63:0]   exp_q[$];
  int            model_bin = 0;
  logic [63:0]   mmax = '0;
  int            mbin = 0;
  bit            pend = 0;
  logic [63:0]   pend_m;
  int            pend_b;
  bit            hold = 0;
  logic [63:0]   hold_m;
  logic [BW-1:0] hold_b;
  int            peak_cnt = 0, last_cnt = 0, stall_cnt = 0;
  logic [63:0]   last_magn = '0, last_pk_m = '0;
  int            last_bin = 0, last_pk_b = 0, first_bin = -1;
  bit            first_pend = 0;

  always @(negedge clk) begin
    logic [63:0] e;
    if (pend) begin
      chk("peak_valid", 64'(peak_valid), 64'd1);
      chk("peak_magn", peak_magn, pend_m);
      chk("peak_bin", 64'(peak_bin), 64'(pend_b));
    end else begin
      chk("peak_idle", 64'(peak_valid), 64'd0);
    end
    if (peak_valid) begin
      peak_cnt++;
      last_pk_m = peak_magn;
      last_pk_b = int'(peak_bin);
    end
    if (hold) begin
      chk("hold_valid", 64'(out_valid), 64'd1);
      chk("hold_magn", out_magn, hold_m);
      chk("hold_bin", 64'(out_bin), 64'(hold_b));
    end
    pend = 0;
    hold = 0;
    if (reset) begin
      exp_q.delete();
      model_bin  = 0;
      mmax       = '0;
      mbin       = 0;
      first_pend = 1;
    end else begin
      chk("in_ready", 64'(in_ready), 64'(!out_valid || out_ready));
      if (out_valid && !in_ready) stall_cnt++;
      if (in_valid && in_ready) exp_q.push_back(model_magn(in_real, in_img));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL extra_output: got out_magn=%0h expected no output", out_magn);
        end else begin
          e = exp_q.pop_front();
          chk("out_magn", out_magn, e);
          chk("out_bin", 64'(out_bin), 64'(model_bin));
          chk("out_last", 64'(out_last), 64'(model_bin == N - 1));
          last_magn = out_magn;
          last_bin  = int'(out_bin);
          if (out_last) last_cnt++;
          if (first_pend) begin
            first_bin  = int'(out_bin);
            first_pend = 0;
          end
          if (model_bin == 0 || e > mmax) begin
            mmax = e;
            mbin = model_bin;
          end
          if (model_bin == N - 1) begin
            pend   = 1;
            pend_m = mmax;
            pend_b = mbin;
          end
          model_bin = (model_bin + 1) % N;
        end
      end
      if (out_valid && !out_ready) begin
        hold   = 1;
        hold_m = out_magn;
        hold_b = out_bin;
      end
    end
  end

  int          b_pk_cnt = 0;
  logic [31:0] b_pk_m = '0;
  logic [1:0]  b_pk_b = '0;
  always @(negedge clk) begin
    if (b_peak_valid) begin
      b_pk_cnt++;
      b_pk_m = b_peak_magn;
      b_pk_b = b_peak_bin;
    end
  end

  // ---------------- output-ready driver ----------------
  int rdy_mode = 0;
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b0;
      endcase
    end
  end

  // ---------------- stimulus tasks ----------------
  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    wait_cycles(n);
    reset = 1'b0;
  endtask

  task automatic send(input logic signed [31:0] re, input logic signed [31:0] im, input bit rand_idle);
    bit hs;
    hs = 0;
    if (rand_idle && ($urandom_range(0, 1) == 1)) begin
      in_valid = 1'b0;
      wait_cycles(1);
    end
    in_valid = 1'b1;
    in_real  = re;
    in_img   = im;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      hs = in_ready;
      @(posedge clk);
      #1;
      if (hs) break;
    end
    if (!hs) begin
      total++;
      bad++;
      $display("FAIL send_timeout: got in_ready=0 for 1000 cycles expected a handshake");
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int c = 0; c < 5000; c++) begin
      if (exp_q.size() == 0 && !out_valid) break;
      wait_cycles(1);
    end
    chk("drain_queue", 64'(exp_q.size()), 64'd0);
    wait_cycles(3);
  endtask

  task automatic b_send(input logic signed [31:0] re, input logic signed [31:0] im,
                        input logic [31:0] exp_m, input logic [1:0] exp_b, input string name);
    bit got;
    got    = 0;
    b_in_valid = 1'b1;
    b_real     = re;
    b_img      = im;
    wait_cycles(1);
    b_in_valid = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (b_out_valid) begin
        got = 1;
        chk(name, 64'(b_out_magn), 64'(exp_m));
        chk({name, "_bin"}, 64'(b_out_bin), 64'(exp_b));
        break;
      end
    end
    if (!got) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: got no b_out_valid expected %0h", name, exp_m);
    end
    wait_cycles(1);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: got no finish by time limit expected test done");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int pk0, lc0, st0;
    reset      = 1'b1;
    in_valid   = 1'b0;
    in_real    = '0;
    in_img     = '0;
    b_in_valid = 1'b0;
    b_real     = '0;
    b_img      = '0;
    b_out_ready = 1'b1;
    wait_cycles(3);
    reset = 1'b0;

    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_magn", out_magn, 64'd0);
    chk("rst_out_bin", 64'(out_bin), 64'd0);
    chk("rst_out_last", 64'(out_last), 64'd0);
    chk("rst_peak_valid", 64'(peak_valid), 64'd0);
    chk("rst_peak_magn", peak_magn, 64'd0);
    chk("rst_peak_bin", 64'(peak_bin), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    wait_cycles(1);

    // (3,4): three-cycle latency, magnitude 25 at bin 0
    send(32'sd3, 32'sd4, 0);
    @(negedge clk);
    chk("lat_c1_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    chk("lat_c2_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    chk("lat_c3_valid", 64'(out_valid), 64'd1);
    chk("lat_c3_magn", out_magn, 64'd25);
    chk("lat_c3_bin", 64'(out_bin), 64'd0);
    chk("lat_c3_last", 64'(out_last), 64'd0);
    wait_cycles(1);

    send(-32'sd2147483648, -32'sd2147483648, 0);
    drain();
    chk("max_neg_magn", last_magn, 64'h8000_0000_0000_0000);
    chk("max_neg_bin", 64'(last_bin), 64'd1);

    // scaled instance: OUT_W=32, SHIFT=16, 4 bins per frame
    b_send(-32'sd2147483648, -32'sd2147483648, 32'hFFFF_FFFF, 2'd0, "b_sat");
    b_send(32'sd256, 32'sd0, 32'd1, 2'd1, "b_256");
    b_send(32'sd255, 32'sd255, 32'd1, 2'd2, "b_255x2");
    b_send(32'sd0, -32'sd32768, 32'd16384, 2'd3, "b_neg32768");
    wait_cycles(2);
    chk("b_peak_cnt", 64'(b_pk_cnt), 64'd1);
    chk("b_peak_magn", 64'(b_pk_m), 64'hFFFF_FFFF);
    chk("b_peak_bin", 64'(b_pk_b), 64'd0);

    // full frame, re = k mod 100
    do_reset(2);
    pk0 = peak_cnt;
    lc0 = last_cnt;
    for (int k = 0; k < N; k++) send(32'(k % 100), 32'sd0, 0);
    drain();
    chk("frame_peak_cnt", 64'(peak_cnt - pk0), 64'd1);
    chk("frame_last_cnt", 64'(last_cnt - lc0), 64'd1);
    chk("frame_peak_magn", last_pk_m, 64'd9801);
    chk("frame_peak_bin", 64'(last_pk_b), 64'd99);

    // five-cycle backpressure mid-stream
    do_reset(2);
    st0 = stall_cnt;
    fork
      begin
        for (int k = 0; k < 40; k++) send(32'(k * 7 - 100), 32'(k), 0);
      end
      begin
        wait_cycles(10);
        rdy_mode = 2;
        wait_cycles(5);
        rdy_mode = 0;
      end
    join
    drain();
    chk("stall_cycles", 64'(stall_cnt - st0), 64'd5);

    // random valid/ready over three frames
    do_reset(2);
    pk0 = peak_cnt;
    rdy_mode = 1;
    for (int k = 0; k < 3 * N; k++) send(32'($urandom), 32'($urandom), 1);
    drain();
    rdy_mode = 0;
    wait_cycles(3);
    chk("rand_peak_cnt", 64'(peak_cnt - pk0), 64'd3);

    // reset near bin 500, then one complete frame
    do_reset(2);
    pk0 = peak_cnt;
    for (int k = 0; k < 503; k++) send(32'(k), 32'(k), 0);
    do_reset(2);
    wait_cycles(5);
    chk("abort_no_peak", 64'(peak_cnt - pk0), 64'd0);
    for (int k = 0; k < N; k++) send(32'(k % 50), 32'sd0, 0);
    drain();
    chk("post_rst_first_bin", 64'(first_bin), 64'd0);
    chk("post_rst_peak_cnt", 64'(peak_cnt - pk0), 64'd1);
    chk("post_rst_peak_magn", last_pk_m, 64'd2401);
    chk("post_rst_peak_bin", 64'(last_pk_b), 64'd49);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
